// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: turns one decoded memory-access request into an AXI4-Lite
// read or write transaction and returns the extended load data with a completion pulse.
module ysyx_23060240_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_rd_en,
    input  logic                  mem_wr_en,
    input  logic [2:0]            memory_rd_ctrl,
    input  logic [1:0]            memory_wr_ctrl,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ld_ctrl_q;
    logic [1:0]        lane_q;
    logic              aw_done_q, w_done_q;

    logic              accept;
    logic              ld_req, st_req;
    logic              ld_misalign, st_misalign;
    logic              ld_ok, st_ok;
    logic              aw_hs, w_hs;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [DATA_W-1:0] ld_value;
    logic [DATA_W/8-1:0] st_strb;
    logic [DATA_W-1:0] st_data;

    always_comb begin
        accept      = req_valid && (state_q == IDLE);
        ld_req      = mem_rd_en && !mem_wr_en;
        st_req      = mem_wr_en && !mem_rd_en;
        ld_misalign = ((memory_rd_ctrl == 3'd3 || memory_rd_ctrl == 3'd4) && addr[0]) ||
                      ((memory_rd_ctrl == 3'd5) && (addr[1:0] != 2'b00));
        st_misalign = ((memory_wr_ctrl == 2'd2) && addr[0]) ||
                      ((memory_wr_ctrl == 2'd3) && (addr[1:0] != 2'b00));
        ld_ok       = ld_req && (memory_rd_ctrl >= 3'd1) && (memory_rd_ctrl <= 3'd5) && !ld_misalign;
        st_ok       = st_req && (memory_wr_ctrl != 2'd0) && !st_misalign;
    end

    // Store lane steering, computed from the raw request so it can be registered at acceptance
    always_comb begin
        st_strb = '1;
        st_data = wdata;
        case (memory_wr_ctrl)
            2'd1: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'd2: begin
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_strb = '1;
                st_data = wdata;
            end
        endcase
    end

    always_comb begin
        rbyte    = rdata[{lane_q, 3'b000} +: 8];
        rhalf    = lane_q[1] ? rdata[31:16] : rdata[15:0];
        ld_value = '0;
        case (ld_ctrl_q)
            3'd1:    ld_value = {{(DATA_W-8){rbyte[7]}}, rbyte};
            3'd2:    ld_value = {{(DATA_W-8){1'b0}}, rbyte};
            3'd3:    ld_value = {{(DATA_W-16){rhalf[15]}}, rhalf};
            3'd4:    ld_value = {{(DATA_W-16){1'b0}}, rhalf};
            3'd5:    ld_value = rdata;
            default: ld_value = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = (state_q == IDLE);
        arvalid    = (state_q == RD_A);
        rready     = (state_q == RD_D);
        awvalid    = (state_q == WR) && !aw_done_q;
        wvalid     = (state_q == WR) && !w_done_q;
        bready     = (state_q == WR_B);
        resp_valid = (state_q == RESP);
        aw_hs      = awvalid && awready;
        w_hs       = wvalid && wready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ld_ok)      state_d = RD_A;
                    else if (st_ok) state_d = WR;
                    else            state_d = RESP;
                end
            end
            RD_A: if (arready) state_d = RD_D;
            RD_D: if (rvalid)  state_d = RESP;
            // AW and W complete independently; leave once both have handshaken
            WR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
            WR_B: if (bvalid)  state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_ctrl_q  <= '0;
            lane_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            araddr     <= '0;
            awaddr     <= '0;
            wdata_o    <= '0;
            wstrb      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ld_ctrl_q  <= memory_rd_ctrl;
                        lane_q     <= addr[1:0];
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        araddr     <= {addr[ADDR_W-1:2], 2'b00};
                        awaddr     <= {addr[ADDR_W-1:2], 2'b00};
                        wdata_o    <= st_data;
                        wstrb      <= st_strb;
                        resp_rdata <= '0;
                        resp_err   <= !(ld_ok || st_ok);
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        resp_err   <= (rresp != 2'b00);
                        resp_rdata <= (rresp != 2'b00) ? '0 : ld_value;
                    end
                end
                WR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WR_B: begin
                    if (bvalid) begin
                        resp_err   <= (bresp != 2'b00);
                        resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Randomized bench for the LSU: acts as an AXI4-Lite slave with random wait states
// and compares every cycle against a transaction-level model of the expected behaviour.
module tb_ysyx_23060240_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  memory_rd_ctrl;
    logic [1:0]  memory_wr_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks;
    int failures;

    ysyx_23060240_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .memory_rd_ctrl(memory_rd_ctrl), .memory_wr_ctrl(memory_wr_ctrl),
        .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] rc, input logic [1:0] wc,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                           input logic [1:0] rr, input logic [1:0] br,
                           input int unsigned arw_in, input int unsigned rw_in,
                           input int unsigned aww_in, input int unsigned ww_in, input int unsigned bw_in);
        int unsigned arw = arw_in, rw = rw_in, aww = aww_in, ww = ww_in, bw = bw_in;
        int unsigned sz = 1;
        logic ld_ok = 1'b0, st_ok = 1'b0;
        logic ar_done = 1'b0, r_done = 1'b0, aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
        logic got = 1'b0;
        logic exp_resp, exp_err;
        logic arv_s, rrd_s, awv_s, wv_s, brd_s;
        logic [31:0] b, h, ld_val, exp_rd, exp_strb, exp_wd;

        if (rd && !wr && rc >= 3'd1 && rc <= 3'd5) begin
            sz = (rc <= 3'd2) ? 1 : (rc <= 3'd4) ? 2 : 4;
            ld_ok = ((a % sz) == 0);
        end
        if (wr && !rd && wc != 2'd0) begin
            sz = (wc == 2'd1) ? 1 : (wc == 2'd2) ? 2 : 4;
            st_ok = ((a % sz) == 0);
        end

        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (rc)
            3'd1:    ld_val = (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd2:    ld_val = b;
            3'd3:    ld_val = (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    ld_val = h;
            default: ld_val = word;
        endcase

        exp_strb = (sz == 1) ? (32'd1 << (a % 4)) : (sz == 2) ? (((a % 4) >= 2) ? 32'd12 : 32'd3) : 32'd15;
        exp_wd   = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

        if (!ld_ok && !st_ok) begin exp_err = 1'b1;       exp_rd = 32'd0; end
        else if (ld_ok)       begin exp_err = (rr != 0);  exp_rd = (rr != 0) ? 32'd0 : ld_val; end
        else                  begin exp_err = (br != 0);  exp_rd = 32'd0; end

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; mem_rd_en = rd; mem_wr_en = wr;
        memory_rd_ctrl = rc; memory_wr_ctrl = wc; addr = a; wdata = wd;
        @(negedge clk);

        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            check("arvalid", arvalid, ld_ok && !ar_done);
            check("rready",  rready,  ld_ok && ar_done && !r_done);
            check("awvalid", awvalid, st_ok && !aw_done);
            check("wvalid",  wvalid,  st_ok && !w_done);
            check("bready",  bready,  st_ok && aw_done && w_done && !b_done);
            if (arvalid) check("araddr", araddr, a & 32'hFFFFFFFC);
            if (awvalid) check("awaddr", awaddr, a & 32'hFFFFFFFC);
            if (wvalid) begin
                check("wstrb",   wstrb,   exp_strb);
                check("wdata_o", wdata_o, exp_wd);
            end
            exp_resp = (!ld_ok && !st_ok) ? (cyc == 1) : ld_ok ? r_done : b_done;
            check("resp_valid", resp_valid, exp_resp);
            if (exp_resp) begin
                check("resp_rdata", resp_rdata, exp_rd);
                check("resp_err", resp_err, exp_err);
                check("req_ready_resp", req_ready, 0);
                got = 1'b1;
            end

            arv_s = arvalid; rrd_s = rready; awv_s = awvalid; wv_s = wvalid; brd_s = bready;

            arready = ld_ok && !ar_done && arw == 0;
            if (ld_ok && !ar_done && arw > 0) arw--;
            rvalid = ld_ok && ar_done && !r_done && rw == 0;
            if (ld_ok && ar_done && !r_done && rw > 0) rw--;
            rdata = rvalid ? word : $urandom;
            rresp = rvalid ? rr : 2'($urandom);
            awready = st_ok && !aw_done && aww == 0;
            if (st_ok && !aw_done && aww > 0) aww--;
            wready = st_ok && !w_done && ww == 0;
            if (st_ok && !w_done && ww > 0) ww--;
            bvalid = st_ok && aw_done && w_done && !b_done && bw == 0;
            if (st_ok && aw_done && w_done && !b_done && bw > 0) bw--;
            bresp = bvalid ? br : 2'($urandom);

            // request-side inputs are junk while busy and must be ignored
            req_valid = 1'($urandom); mem_rd_en = 1'($urandom); mem_wr_en = 1'($urandom);
            memory_rd_ctrl = 3'($urandom); memory_wr_ctrl = 2'($urandom);
            addr = $urandom; wdata = $urandom;

            @(negedge clk);
            if (arv_s && arready) ar_done = 1'b1;
            if (rrd_s && rvalid)  r_done  = 1'b1;
            if (awv_s && awready) aw_done = 1'b1;
            if (wv_s && wready)   w_done  = 1'b1;
            if (brd_s && bvalid)  b_done  = 1'b1;
        end
        check("resp_seen", got, 1);
        req_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        check("resp_valid_drop", resp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic rd, wr;
        logic [2:0] rc;
        logic [1:0] wc;
        int unsigned sel;

        checks = 0; failures = 0;
        rst_n = 1'b0; req_valid = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        memory_rd_ctrl = '0; memory_wr_ctrl = '0; addr = '0; wdata = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;

        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_araddr", araddr, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata_o", wdata_o, 0);
        check("rst_wstrb", wstrb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_txn(1, 0, 3'd1, 2'd0, 32'h80000003, 32'h0, 32'h80ABCDEF, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 0, 3'd2, 2'd0, 32'h80000003, 32'h0, 32'h80ABCDEF, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 0, 3'd3, 2'd0, 32'h80000002, 32'h0, 32'h80011234, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 0, 3'd4, 2'd0, 32'h80000002, 32'h0, 32'h80011234, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 0, 3'd5, 2'd0, 32'h80000004, 32'h0, 32'h12345678, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(0, 1, 3'd0, 2'd2, 32'h80000006, 32'h0000BEEF, 32'h0, 2'b00, 2'b00, 0, 0, 3, 0, 0);
        run_txn(1, 0, 3'd5, 2'd0, 32'h80000001, 32'h0, 32'h12345678, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 1, 3'd5, 2'd3, 32'h80000000, 32'h0, 32'h12345678, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        run_txn(0, 1, 3'd0, 2'd1, 32'h80000001, 32'h000000A5, 32'h0, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        run_txn(1, 0, 3'd5, 2'd0, 32'h80000008, 32'h0, 32'hDEADBEEF, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        run_txn(0, 1, 3'd0, 2'd3, 32'h80000010, 32'hCAFEF00D, 32'h0, 2'b00, 2'b00, 0, 2, 1, 3, 2);

        // reset while a read is waiting for rvalid
        mem_rd_en = 1'b1; mem_wr_en = 1'b0; memory_rd_ctrl = 3'd5; addr = 32'h80000008; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("mid_rready", rready, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_req_ready", req_ready, 1);
        @(negedge clk);
        check("mid_rst_no_resp", resp_valid, 0);
        run_txn(1, 0, 3'd5, 2'd0, 32'h8000000C, 32'h0, 32'h0BADC0DE, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            rd = (sel < 5) ? 1'b1 : (sel < 9) ? 1'b0 : 1'($urandom);
            wr = (sel < 5) ? 1'b0 : (sel < 9) ? 1'b1 : 1'($urandom);
            rc = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom);
            wc = 2'($urandom);
            run_txn(rd, wr, rc, wc, 32'h80000000 + $urandom_range(0, 255), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
